archie_rom_loader: RTL

Bridge between the HPS ioctl download stream and the SDRAM Wishbone port. It packs 16-bit ioctl halfwords into 32-bit SDRAM writes at a fixed base address and throttles the HPS with `ioctl_wait`. It also arbitrates the SDRAM port between the loader and the Archimedes core, so the core never sees an acknowledge for a loader cycle. It sits between `hps_io`/core and `sdram`, replacing the inline loader mux at the top level.

---
 rtl/archie_pkg.sv | 41 ++++
 rtl/wb_port_mux.sv | 21 ++
 rtl/archie_rom_loader.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/archie_pkg.sv
// Shared types and constants for the Archimedes ROM loader and its port mux.
package archie_pkg;

  localparam int unsigned RAM_AW  = 26;
  localparam int unsigned CORE_AW = 24;
  localparam int unsigned WORD_AW = 22;
  localparam int unsigned DAT_W   = 32;
  localparam int unsigned HALF_W  = 16;
  localparam int unsigned CNT_W   = 23;

  localparam logic [3:0] SEL_LO      = 4'b0011;
  localparam logic [3:0] SEL_HI      = 4'b1100;
  localparam logic [3:0] SEL_ALL     = 4'b1111;
  localparam logic [2:0] CTI_CLASSIC = 3'b000;

  typedef enum logic [2:0] {
    ST_PASS,
    ST_DRAIN,
    ST_LOAD,
    ST_WRITE,
    ST_FLUSH
  } ldr_state_t;

  // One Wishbone master request towards the SDRAM port.
  typedef struct packed {
    logic                stb;
    logic                cyc;
    logic                we;
    logic [3:0]          sel;
    logic [2:0]          cti;
    logic [RAM_AW-1:0]   adr;
    logic [DAT_W-1:0]    dat;
  } wb_req_t;

  // Byte address of a 32-bit word offset relative to a base.
  function automatic logic [RAM_AW-1:0] word_byte_addr(input logic [RAM_AW-1:0]  base,
                                                       input logic [WORD_AW-1:0] word);
    return base + {2'b00, word, 2'b00};
  endfunction

endpackage

// File: rtl/wb_port_mux.sv
// 2:1 Wishbone master mux; the acknowledge goes only to the selected master.
module wb_port_mux
  import archie_pkg::*;
(
  input  logic    sel_b,
  input  wb_req_t a_req,
  input  wb_req_t b_req,
  output wb_req_t m_req,
  input  logic    m_ack,
  output logic    a_ack,
  output logic    b_ack
);

  // Route the selected request and steer the returning ack.
  always_comb begin
    m_req = sel_b ? b_req : a_req;
    a_ack = m_ack & ~sel_b;
    b_ack = m_ack & sel_b;
  end

endmodule

// File: rtl/archie_rom_loader.sv
// Packs ioctl halfwords into 32-bit SDRAM writes and shares the SDRAM port with the core.
module archie_rom_loader
  import archie_pkg::*;
#(
  parameter logic [25:0] BASE_ADDR = 26'h0400000,
  parameter logic [7:0]  INDEX     = 8'd1
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic                ioctl_download,
  input  logic [7:0]          ioctl_index,
  input  logic                ioctl_wr,
  input  logic [24:0]         ioctl_addr,
  input  logic [HALF_W-1:0]   ioctl_dout,
  output logic                ioctl_wait,
  input  logic                core_stb,
  input  logic                core_cyc,
  input  logic                core_we,
  input  logic [3:0]          core_sel,
  input  logic [2:0]          core_cti,
  input  logic [CORE_AW-1:0]  core_adr,
  input  logic [DAT_W-1:0]    core_dat,
  output logic                core_ack,
  output logic                ram_stb,
  output logic                ram_cyc,
  output logic                ram_we,
  output logic [3:0]          ram_sel,
  output logic [2:0]          ram_cti,
  output logic [RAM_AW-1:0]   ram_adr,
  output logic [DAT_W-1:0]    ram_dat,
  input  logic                ram_ack,
  output logic                busy,
  output logic [CNT_W-1:0]    words
);

  ldr_state_t          state, state_n;
  logic [HALF_W-1:0]   lo, lo_n;
  logic                lo_valid, lo_valid_n;
  logic [WORD_AW-1:0]  lo_word, lo_word_n;
  logic                ld_stb, ld_stb_n;
  logic [RAM_AW-1:0]   ld_adr, ld_adr_n;
  logic [DAT_W-1:0]    ld_dat, ld_dat_n;
  logic [3:0]          ld_sel, ld_sel_n;
  logic [CNT_W-1:0]    words_n;

  logic                active;
  logic [WORD_AW-1:0]  wr_word;
  logic                lo_match;
  logic                sel_loader;
  logic                ld_ack;
  wb_req_t             core_req, ld_req, ram_req;
  logic                unused_addr_bits;

  assign unused_addr_bits = ^{ioctl_addr[24], ioctl_addr[0]};

  // Decode of the download stream against this loader's index.
  always_comb begin
    active   = ioctl_download & (ioctl_index == INDEX);
    wr_word  = ioctl_addr[23:2];
    lo_match = lo_valid & (lo_word == wr_word);
  end

  // State, pending-half and write-request registers.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state    <= ST_PASS;
      lo       <= '0;
      lo_valid <= 1'b0;
      lo_word  <= '0;
      ld_stb   <= 1'b0;
      ld_adr   <= '0;
      ld_dat   <= '0;
      ld_sel   <= '0;
      words    <= '0;
    end else begin
      state    <= state_n;
      lo       <= lo_n;
      lo_valid <= lo_valid_n;
      lo_word  <= lo_word_n;
      ld_stb   <= ld_stb_n;
      ld_adr   <= ld_adr_n;
      ld_dat   <= ld_dat_n;
      ld_sel   <= ld_sel_n;
      words    <= words_n;
    end
  end

  // Next-state, halfword packing and HPS throttle.
  always_comb begin
    state_n    = state;
    lo_n       = lo;
    lo_valid_n = lo_valid;
    lo_word_n  = lo_word;
    ld_stb_n   = ld_stb;
    ld_adr_n   = ld_adr;
    ld_dat_n   = ld_dat;
    ld_sel_n   = ld_sel;
    words_n    = words;
    ioctl_wait = 1'b0;

    unique case (state)
      ST_PASS: begin
        if (active) begin
          state_n = ST_DRAIN;
          words_n = '0;
        end
      end

      ST_DRAIN: begin
        ioctl_wait = 1'b1;
        if (!core_cyc || ram_ack) state_n = ST_LOAD;
      end

      ST_LOAD: begin
        if (!active) begin
          if (lo_valid) begin
            state_n    = ST_FLUSH;
            ld_stb_n   = 1'b1;
            ld_adr_n   = word_byte_addr(BASE_ADDR, lo_word);
            ld_dat_n   = {lo, lo};
            ld_sel_n   = SEL_LO;
            lo_valid_n = 1'b0;
          end else begin
            state_n = ST_PASS;
          end
        end else if (ioctl_wr) begin
          if (ioctl_addr[1]) begin
            // High half: complete the word if its low half is pending.
            ioctl_wait = 1'b1;
            state_n    = ST_WRITE;
            ld_stb_n   = 1'b1;
            ld_adr_n   = word_byte_addr(BASE_ADDR, wr_word);
            if (lo_match) begin
              ld_dat_n   = {ioctl_dout, lo};
              ld_sel_n   = SEL_ALL;
              lo_valid_n = 1'b0;
            end else begin
              ld_dat_n = {ioctl_dout, ioctl_dout};
              ld_sel_n = SEL_HI;
            end
          end else begin
            if (lo_valid && !lo_match) begin
              // Orphaned low half of another word goes out before it is replaced.
              ioctl_wait = 1'b1;
              state_n    = ST_WRITE;
              ld_stb_n   = 1'b1;
              ld_adr_n   = word_byte_addr(BASE_ADDR, lo_word);
              ld_dat_n   = {lo, lo};
              ld_sel_n   = SEL_LO;
            end
            lo_n       = ioctl_dout;
            lo_word_n  = wr_word;
            lo_valid_n = 1'b1;
          end
        end
      end

      ST_WRITE: begin
        ioctl_wait = 1'b1;
        if (ld_ack) begin
          ld_stb_n = 1'b0;
          words_n  = words + CNT_W'(1);
          state_n  = ST_LOAD;
        end
      end

      ST_FLUSH: begin
        ioctl_wait = 1'b1;
        if (ld_ack) begin
          ld_stb_n = 1'b0;
          words_n  = words + CNT_W'(1);
          state_n  = ST_PASS;
        end
      end

      default: state_n = ST_PASS;
    endcase
  end

  // Port ownership and request payloads for both masters.
  always_comb begin
    busy       = (state != ST_PASS);
    sel_loader = (state == ST_LOAD) || (state == ST_WRITE) || (state == ST_FLUSH);

    core_req.stb = core_stb;
    core_req.cyc = core_cyc;
    core_req.we  = core_we;
    core_req.sel = core_sel;
    core_req.cti = core_cti;
    core_req.adr = {core_adr, 2'b00};
    core_req.dat = core_dat;

    ld_req.stb = ld_stb;
    ld_req.cyc = ld_stb;
    ld_req.we  = 1'b1;
    ld_req.sel = ld_sel;
    ld_req.cti = CTI_CLASSIC;
    ld_req.adr = ld_adr;
    ld_req.dat = ld_dat;
  end

  wb_port_mux u_mux (
    .sel_b (sel_loader),
    .a_req (core_req),
    .b_req (ld_req),
    .m_req (ram_req),
    .m_ack (ram_ack),
    .a_ack (core_ack),
    .b_ack (ld_ack)
  );

  // Flatten the selected request onto the SDRAM port.
  always_comb begin
    ram_stb = ram_req.stb;
    ram_cyc = ram_req.cyc;
    ram_we  = ram_req.we;
    ram_sel = ram_req.sel;
    ram_cti = ram_req.cti;
    ram_adr = ram_req.adr;
    ram_dat = ram_req.dat;
  end

endmodule
